// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

    localparam int DMEM_DEPTH = 1024;
    localparam int IDX_W      = 10;
    localparam int CNT_W      = 4;

    localparam logic [31:0] INIT_WORD1 = 32'hFFFF_FFFF;
    localparam logic [31:0] INIT_WORD4 = 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word RAM with registered read and the pipeline's boot image.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             re,
    input  logic             rzero,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      q
);

    logic [31:0] mem_r [DEPTH] = '{1: INIT_WORD1, 4: INIT_WORD4, default: 32'h0000_0000};

    // Read port register; reset clears only this register, never the storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 32'h0000_0000;
        end else if (re) begin
            q <= rzero ? 32'h0000_0000 : mem_r[addr];
        end else begin
            q <= q;
        end
    end

    // Storage write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target for the MEM stage: valid/ack handshake, fixed latency.
// Optional misalignment reporting is built only when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = DMEM_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err
);

    localparam bit               LAT_ONE  = (LATENCY == 32'sd1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             we_r;
    logic [IDX_W-1:0] idx_r;
    logic [31:0]      wdata_r;
    logic             ack_r;
    logic             busy_r;

    logic             enter_resp_s;
    logic             mis_now_s;
    logic             arr_we_s;
    logic [IDX_W-1:0] arr_idx_s;
    logic             unused_addr_s;

    // Upper address bits wrap the 4 KB window; low bits matter only to the check.
    assign unused_addr_s = ^{addr[31:12], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_r;
    logic err_r;

    // Misalignment of the request being serviced; live address while still in IDLE.
    always_comb begin
        if (state_r == IDLE) begin
            mis_now_s = misaligned(addr[1:0]);
        end else begin
            mis_now_s = mis_r;
        end
    end

    assign err = err_r;
`else
    assign mis_now_s = 1'b0;
    assign err       = 1'b0;
`endif

    // RESP entry detection and array port steering (IDLE reads the live address for LATENCY=1).
    always_comb begin
        enter_resp_s = 1'b0;
        arr_idx_s    = idx_r;
        arr_we_s     = 1'b0;
        case (state_r)
            IDLE: begin
                arr_idx_s = addr[11:2];
                if (req && LAT_ONE) begin
                    enter_resp_s = 1'b1;
                end else begin
                    enter_resp_s = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    enter_resp_s = 1'b1;
                end else begin
                    enter_resp_s = 1'b0;
                end
            end
            RESP: begin
                arr_we_s = we_r & ~mis_now_s & ~reset;
            end
            default: begin
                enter_resp_s = 1'b0;
            end
        endcase
    end

    // Handshake FSM, latency counter and request capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            mis_r   <= 1'b0;
            err_r   <= 1'b0;
`endif
        end else begin
            ack_r <= enter_resp_s;
`ifdef DMEM_ALIGN_CHECK_EN
            err_r <= enter_resp_s & mis_now_s;
`endif
            case (state_r)
                IDLE: begin
                    if (req) begin
                        we_r    <= we;
                        idx_r   <= addr[11:2];
                        wdata_r <= wdata;
                        cnt_r   <= CNT_LOAD;
                        busy_r  <= 1'b1;
                        state_r <= LAT_ONE ? RESP : WAIT;
`ifdef DMEM_ALIGN_CHECK_EN
                        mis_r   <= mis_now_s;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                WAIT: begin
                    busy_r <= 1'b1;
                    if (cnt_r == CNT_ONE) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= RESP;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ack  = ack_r;
    assign busy = busy_r;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .re    (enter_resp_s),
        .rzero (mis_now_s),
        .we    (arr_we_s),
        .addr  (arr_idx_s),
        .wdata (wdata_r),
        .q     (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances at LATENCY 1, 2 and 3, table vectors,
// hand sequences for reset corners, then random traffic against a word-array model.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk;
    logic        reset [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        busy  [3];
    logic        err   [3];
    logic        req_q [3];

    logic [31:0] model [3][1024];

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int          d;
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        bit          hold;
        logic [31:0] rd;
        bit          er;
    } vec_t;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(1)) u_l1 (
        .clock(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .err(err[0]));
    dmem_responder #(.LATENCY(2)) u_l2 (
        .clock(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .err(err[1]));
    dmem_responder #(.LATENCY(3)) u_l3 (
        .clock(clk), .reset(reset[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .busy(busy[2]), .err(err[2]));

    // Initiator must hold req until ack once a request is in flight.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset[i] !== 1'b1 && req_q[i] === 1'b1 && busy[i] === 1'b1 && ack[i] !== 1'b1)
                assert (req[i] === 1'b1) else $error("FAIL req_protocol dut%0d: req=%b required 1", i, req[i]);
            req_q[i] <= req[i];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return d + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit is_mis(input logic [31:0] a);
        return ALIGN_CHK && (a[1:0] != 2'b00);
    endfunction

    // Called at a negedge; returns at the negedge of the idle cycle after ack.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, input logic [31:0] exp_rd, input bit exp_err);
        int n;
        bit got;
        bit busy_ok;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        n = 0; got = 1'b0; busy_ok = 1'b1;
        @(posedge clk);
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (busy[d] !== 1'b1) busy_ok = 1'b0;
            if (ack[d] === 1'b1) got = 1'b1;
        end
        chk($sformatf("ack_latency d%0d a=%h", d, a), n, lat_of(d));
        chk($sformatf("busy_high d%0d a=%h", d, a), {31'b0, busy_ok}, 32'd1);
        chk($sformatf("rdata d%0d we=%0d a=%h", d, w, a), rdata[d], exp_rd);
        chk($sformatf("err d%0d a=%h", d, a), {31'b0, err[d]}, {31'b0, exp_err});
        if (w && !is_mis(a)) model[d][a[11:2]] = wd;
        if (!hold) req[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("ack_after d%0d", d), {31'b0, ack[d]}, 32'd0);
        chk($sformatf("busy_after d%0d", d), {31'b0, busy[d]}, 32'd0);
    endtask

    task automatic model_txn(input int d, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input bit hold);
        logic [31:0] e;
        e = is_mis(a) ? 32'h0 : model[d][a[11:2]];
        txn(d, w, a, wd, hold, e, is_mis(a));
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 1024; k++) model[d][k] = 32'h0;
            model[d][1] = 32'hFFFF_FFFF;
            model[d][4] = 32'hFFFF_FFFE;
            reset[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
            addr[d] = 32'h0; wdata[d] = 32'h0; req_q[d] = 1'b0;
        end

        vecs[0] = '{1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_0014, 32'h0000_000C, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{1, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h0000_000C, 1'b0};
        vecs[3] = '{0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0};
        vecs[4] = '{0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[5] = '{1, 1'b0, 32'h0000_1004, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[6] = '{1, 1'b1, 32'h0000_0006, 32'h1234_5678, 1'b0, 32'h0, 1'b1};
        vecs[7] = '{1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0};
`else
        vecs[6] = '{1, 1'b1, 32'h0000_0006, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h1234_5678, 1'b0};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_ack d%0d", d), {31'b0, ack[d]}, 32'd0);
            chk($sformatf("reset_busy d%0d", d), {31'b0, busy[d]}, 32'd0);
            chk($sformatf("reset_err d%0d", d), {31'b0, err[d]}, 32'd0);
            chk($sformatf("reset_rdata d%0d", d), rdata[d], 32'd0);
            reset[d] = 1'b0;
        end
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            txn(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].hold, vecs[i].rd, vecs[i].er);

        // Reset one cycle after accepting a store on the LATENCY=3 instance.
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0000_0008; wdata[2] = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        reset[2] = 1'b1; req[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_wait_ack", {31'b0, ack[2]}, 32'd0);
            chk("rst_wait_busy", {31'b0, busy[2]}, 32'd0);
        end
        reset[2] = 1'b0;
        @(negedge clk);
        txn(2, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h0, 1'b0);

        // Reset and req together on the LATENCY=2 instance: request must not be taken.
        reset[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_0020; wdata[1] = 32'hAAAA_5555;
        @(posedge clk);
        @(negedge clk);
        reset[1] = 1'b0; req[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_req_ack", {31'b0, ack[1]}, 32'd0);
            chk("rst_req_busy", {31'b0, busy[1]}, 32'd0);
        end
        txn(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0, 1'b0);

        // Random bursts of four, req sometimes held between requests to the same instance.
        for (int b = 0; b < 75; b++) begin
            int d;
            d = int'($urandom_range(0, 2));
            for (int k = 0; k < 4; k++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2);
                if ($urandom_range(0, 3) == 0) a = a | $urandom_range(1, 3);
                model_txn(d, 1'($urandom_range(0, 1)), a, $urandom,
                          (k < 3) && ($urandom_range(0, 1) == 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS pipeline's MEM stage: services load and store requests over a valid/acknowledge handshake with a configurable fixed latency. It replaces the zero-latency data-memory array with a multi-cycle target, so the pipeline's MEM stage acts as the initiator and must stall until `ack`. Storage is 1024 words of 32 bits, byte-addressed and word-aligned, with the same initial image the pipeline bench uses.

## Interface
- `LATENCY`, default 2: cycles from the accepting clock edge to `ack` high; legal range 1–15.
- `DEPTH`, default 1024: number of 32-bit words.
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  request valid; held high with fields stable until `ack`.
- `we`  in  1  1 = store (SW), 0 = load (LW).
- `addr`  in  32  byte address, i.e. the ALU result from EX.
- `wdata`  in  32  store data, i.e. the B value carried down the pipeline.
- `ack`  out  1  one-cycle response strobe.
- `rdata`  out  32  load data; valid while `ack`=1.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `err`  out  1  misalignment flag, qualified by `ack` (only with DMEM_ALIGN_CHECK_EN).

## Operation
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE with `req`=1: capture `we`, word index `addr[11:2]`, `wdata`; load the latency counter with `LATENCY-1`.
  - From IDLE, go to RESP if `LATENCY`=1, otherwise to WAIT.
  - WAIT: decrement the counter each cycle; go to RESP in the cycle after the counter reads 1.
  - RESP: `ack`=1 for exactly one cycle, then return to IDLE unconditionally.
- **Stores:** the array write happens on the RESP edge, with the write data captured at accept. `rdata` in a store's RESP cycle holds the pre-write word.
- **Loads:** `rdata` is registered from the array on entry to RESP and holds its value until the next RESP.
- **Addressing:** `addr[31:12]` is ignored, so addresses wrap modulo 4 KB. `addr[1:0]` is handled per Configuration.
- **Back-to-back requests:** no request is accepted in RESP. A `req` still high in the cycle after `ack` is a new request, accepted in IDLE. Minimum spacing between acks is therefore `LATENCY`+1 cycles.
- **Initial contents at time zero:** word 1 = 0xFFFFFFFF, word 4 = 0xFFFFFFFE, all other words 0. `reset` never alters the array.

## Timing
- **Reset values:** state IDLE, `ack`=0, `busy`=0, `err`=0, `rdata`=0, counter 0.
- **Latency:** the request is accepted at edge T, and `ack` is high in the cycle after edge T+`LATENCY`-1, i.e. `ack` is visible `LATENCY` cycles after accept.
- **`busy`:** high from the cycle after accept through the RESP cycle inclusive.
- **Reset mid-operation:** the FSM returns to IDLE and no `ack` is issued. A store not yet in RESP is dropped, and the array is unchanged.
- **`req` dropped before `ack`:** protocol violation. The captured request completes anyway, and the bench flags the violation as an assertion.
- **Simultaneous `reset` and `req`:** reset wins; the request is not accepted.

## Configuration
- **`DMEM_ALIGN_CHECK_EN` defined:** a request with `addr[1:0]`≠0 still completes the handshake with normal latency. At its `ack`, `err`=1, `rdata`=0, and a store performs no write. `err`=0 for aligned requests.
- **`DMEM_ALIGN_CHECK_EN` undefined:** `addr[1:0]` is ignored, the `err` port is tied to 0, and no check logic is built.

## Structure
- **Package `dmem_pkg`:** state enum (IDLE, WAIT, RESP), `DMEM_DEPTH`=1024, word-index width (10), counter width (4), and the initial-image constants (word 1 and word 4 values).
- **Sub-module `dmem_array`:** synchronous single-port 32×`DEPTH` RAM with write enable, registered read, and the initial image.
- **`dmem_responder` itself:** FSM, counter, capture registers and alignment check.

## Test plan
- **Load, LATENCY=2:** req LW at `addr`=0x4 → `ack` exactly 2 cycles after accept, `rdata`=0xFFFFFFFF, `busy` high for 2 cycles.
- **Store then load:** SW `addr`=0x14, `wdata`=0x0000000C → `ack` with `rdata`=0 (pre-write word); then LW 0x14 → `rdata`=0x0000000C.
- **Back-to-back with LATENCY=1:** two LW requests (0x10, then 0x0) with `req` held high → acks 2 cycles apart, `rdata` 0xFFFFFFFE then 0x0.
- **Reset in WAIT (LATENCY=3):** SW 0x8, `wdata`=0xDEADBEEF, reset one cycle after accept → no `ack`, `busy`=0 after reset, later LW 0x8 returns 0.
- **Address wrap:** LW `addr`=0x1004 → `rdata`=0xFFFFFFFF (same word as 0x4).
- **Misaligned store, macro defined:** SW `addr`=0x6, `wdata`=0x12345678 → `ack` with `err`=1, `rdata`=0; LW 0x4 still returns 0xFFFFFFFF.
- **Misaligned store, macro undefined:** the same SW writes word 1; LW 0x4 returns 0x12345678.
